alarm_response_controller: RTL and testbench

Sequential consumer of the comparator bank's activate-alarm output (AA). It turns a match on the current time/day into a ringing session. It handles snooze and stop requests, times out an unattended alarm, and drives the buzzer and status outputs for the display. It sits between `comparators_module` and the buzzer/LED drivers, on the same single clock domain as the time-keeping counters.

---
 rtl/alarm_response_controller.sv | 139 +++++++++++++
 tb/tb_alarm_response_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_response_controller.sv
// Alarm response FSM: rings on AA rising edge, handles snooze/stop/timeout.
// Define ALARM_BUZZER_PULSE_EN for a 1 s on / 1 s off buzzer pattern.
module alarm_response_controller #(
  parameter int SNOOZE_TICKS = 300,
  parameter int RING_TICKS   = 120,
  parameter int MAX_SNOOZES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       AA,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_count,
  output logic       missed
);

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  localparam logic [15:0] RING_LAST   = 16'(RING_TICKS - 1);
  localparam logic [15:0] SNOOZE_INIT = 16'(SNOOZE_TICKS);
  localparam logic [2:0]  MAX_S       = 3'(MAX_SNOOZES);

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [1:0]  count_n;
  logic        missed_n;
  logic        aa_q;
  logic        phase, phase_n;
  logic        trigger;
  logic        restart;
  logic        can_snooze;
  logic        buzzer_n;

  assign trigger    = AA & ~aa_q;
  assign can_snooze = {1'b0, snooze_count} < MAX_S;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    count_n  = snooze_count;
    missed_n = missed;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop_btn)
          missed_n = 1'b0;
        if (trigger && alarm_en) begin
          state_n = RING;
          timer_n = '0;
          count_n = '0;
          restart = 1'b1;
        end
      end
      RING, SNOOZE: begin
        if (!alarm_en) begin
          state_n = IDLE;
        end else if (stop_btn) begin
          state_n  = IDLE;
          missed_n = 1'b0;
        end else if (trigger) begin
          state_n = RING;
          timer_n = '0;
          count_n = '0;
          restart = 1'b1;
        end else if (snooze_btn && state == RING && can_snooze) begin
          state_n = SNOOZE;
          timer_n = SNOOZE_INIT;
          count_n = snooze_count + 2'd1;
        end else if (tick) begin
          if (state == RING) begin
            if (timer >= RING_LAST) begin
              state_n  = IDLE;
              missed_n = 1'b1;
            end else begin
              timer_n = timer + 16'd1;
            end
          end else begin
            if (timer <= 16'd1) begin
              state_n = RING;
              timer_n = '0;
            end else begin
              timer_n = timer - 16'd1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // phase restarts high on every entry into RING, toggles per tick while ringing
  always_comb begin
    phase_n = phase;
    if (state_n == RING && (state != RING || restart))
      phase_n = 1'b1;
    else if (state == RING && tick)
      phase_n = ~phase;
  end

`ifdef ALARM_BUZZER_PULSE_EN
  assign buzzer_n = (state_n == RING) & phase_n;
`else
  assign buzzer_n = (state_n == RING);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      snooze_count <= '0;
      missed       <= 1'b0;
      aa_q         <= 1'b1;
      phase        <= 1'b1;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      snooze_count <= count_n;
      missed       <= missed_n;
      aa_q         <= AA;
      phase        <= phase_n;
      buzzer       <= buzzer_n;
      ringing      <= (state_n == RING);
      snoozing     <= (state_n == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_response_controller.sv
// Bench for alarm_response_controller: slot table with scoreboard queue,
// plus hand sequences for reset, AA latency and buzzer pattern.
module tb_alarm_response_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       AA;
  logic       alarm_en;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic       missed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       aa, en, snz, stp;
    logic       r, s;
    logic [1:0] c;
    logic       m;
  } vec_t;

  typedef struct {
    int         idx;
    logic       r, s;
    logic [1:0] c;
    logic       m;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  alarm_response_controller #(
    .SNOOZE_TICKS(3),
    .RING_TICKS  (5),
    .MAX_SNOOZES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .AA          (AA),
    .alarm_en    (alarm_en),
    .snooze_btn  (snooze_btn),
    .stop_btn    (stop_btn),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_count(snooze_count),
    .missed      (missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic aa, en, snz, stp,
                     input logic r, s, input int c, input logic m);
    vec_t v;
    v.aa = aa; v.en = en; v.snz = snz; v.stp = stp;
    v.r = r; v.s = s; v.c = 2'(c); v.m = m;
    tbl.push_back(v);
  endtask

  // One slot: buttons on the first clock, tick on the fourth.
  task automatic run_slot(input int i);
    exp_t e;
    exp_t g;
    AA         = tbl[i].aa;
    alarm_en   = tbl[i].en;
    snooze_btn = tbl[i].snz;
    stop_btn   = tbl[i].stp;
    e.idx = i; e.r = tbl[i].r; e.s = tbl[i].s;
    e.c = tbl[i].c; e.m = tbl[i].m;
    sb.push_back(e);
    cyc();
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    g = sb.pop_front();
    chk($sformatf("row%0d ringing", g.idx), int'(ringing), int'(g.r));
    chk($sformatf("row%0d snoozing", g.idx), int'(snoozing), int'(g.s));
    chk($sformatf("row%0d count", g.idx), int'(snooze_count), int'(g.c));
    chk($sformatf("row%0d missed", g.idx), int'(missed), int'(g.m));
`ifndef ALARM_BUZZER_PULSE_EN
    chk($sformatf("row%0d buzzer", g.idx), int'(buzzer), int'(g.r));
`endif
  endtask

  initial begin
    for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1, 2, 0);
    add(1, 1, 0, 0, 0, 1, 2, 0);
    add(1, 1, 0, 0, 1, 0, 2, 0);
    add(1, 1, 1, 0, 1, 0, 2, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 1, 0, 2, 0);
    add(1, 1, 0, 0, 0, 0, 2, 1);
    add(0, 1, 0, 0, 0, 0, 2, 1);
    add(1, 1, 0, 0, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1, 1, 1);
    add(1, 0, 1, 1, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1, 1, 1);
    add(1, 1, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);

    reset = 1'b1; tick = 1'b0; AA = 1'b1; alarm_en = 1'b1;
    snooze_btn = 1'b0; stop_btn = 1'b0;
    cyc();
    chk("reset ringing", int'(ringing), 0);
    chk("reset buzzer", int'(buzzer), 0);
    chk("reset count", int'(snooze_count), 0);
    cyc();
    reset = 1'b0;

    foreach (tbl[i]) run_slot(i);
    chk("scoreboard drained", sb.size(), 0);

    // Mid-session reset with timer at 3: asynchronous, no clock needed.
    reset = 1'b1;
    #1;
    chk("async rst ringing", int'(ringing), 0);
    chk("async rst snoozing", int'(snoozing), 0);
    chk("async rst buzzer", int'(buzzer), 0);
    chk("async rst count", int'(snooze_count), 0);
    chk("async rst missed", int'(missed), 0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick = (k % 4 == 3);
      cyc();
    end
    tick = 1'b0;
    chk("no ring after reset", int'(ringing), 0);

    AA = 1'b0;
    cyc();
    chk("pre-edge ringing", int'(ringing), 0);
    AA = 1'b1;
    cyc();
    chk("latency ringing", int'(ringing), 1);
    chk("latency buzzer", int'(buzzer), 1);
    chk("latency count", int'(snooze_count), 0);

    for (int k = 0; k < 4; k++) begin
      cyc();
`ifdef ALARM_BUZZER_PULSE_EN
      chk($sformatf("buzz interval %0d", k), int'(buzzer), (k % 2 == 0) ? 1 : 0);
`else
      chk($sformatf("buzz interval %0d", k), int'(buzzer), 1);
`endif
      cyc();
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
    chk("still ringing at 4 ticks", int'(ringing), 1);
    cyc();
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("timeout ringing", int'(ringing), 0);
    chk("timeout missed", int'(missed), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
